// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one outstanding memory read per accepted PC and
// buffers {pc, instr} in an in-order FWFT circular queue; flush discards queued and in-flight data.
module fetch_queue #(
  parameter int WIDTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      pc_in,
  input  logic                  pc_valid,
  output logic                  pc_ready,
  output logic                  mem_req,
  output logic [WIDTH-1:0]      mem_addr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  flush,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0]      instr_pc,
  input  logic                  instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                state_q;
  logic [AW:0]           count_q, count_d;
  logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [WIDTH-1:0]      pend_pc_q;
  logic [WIDTH-1:0]      pc_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] dat_mem_q [DEPTH];

  logic push, pop;

  always_comb begin
    pc_ready    = (state_q == IDLE) && (count_q < CNT_FULL) && !flush;
    mem_req     = pc_valid && pc_ready;
    mem_addr    = pc_in;
    instr_valid = (count_q != '0) && !flush;
    instr_out   = dat_mem_q[rd_ptr_q];
    instr_pc    = pc_mem_q[rd_ptr_q];
    // Flush already masks pop via instr_valid; push must be masked explicitly.
    push        = (state_q == WAIT) && mem_rvalid && !flush;
    pop         = instr_valid && instr_ready;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      pend_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        dat_mem_q[i] <= '0;
      end
    end else begin
      if (flush) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]  <= pend_pc_q;
          dat_mem_q[wr_ptr_q] <= mem_rdata;
          wr_ptr_q            <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
      end

      case (state_q)
        IDLE: begin
          // mem_req already excludes flush and a full queue.
          if (mem_req) begin
            state_q   <= WAIT;
            pend_pc_q <= pc_in;
          end
        end
        WAIT: begin
          if (mem_rvalid)  state_q <= IDLE;
          else if (flush)  state_q <= DROP;
        end
        DROP: begin
          if (mem_rvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: inputs change at the falling edge, outputs checked 1ns later.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue #(.WIDTH(16), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .flush(flush),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and return all inputs to idle.
  task automatic cyc();
    @(negedge clk);
    pc_valid = 1'b0; mem_rvalid = 1'b0; flush = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] pc, input logic [31:0] d);
    chk({tag, "_valid"}, instr_valid, 1'b1);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_dat"}, instr_out, d);
  endtask

  initial begin
    rst = 1'b0; pc_in = '0; pc_valid = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; flush = 1'b0; instr_ready = 1'b0;

    // Reset state
    cyc(); cyc();
    #1;
    chk("rst_ivalid", instr_valid, 1'b0);
    chk("rst_iout", instr_out, 32'h0);
    chk("rst_ipc", instr_pc, 16'h0);
    chk("rst_mreq", mem_req, 1'b0);
    cyc(); rst = 1'b1;
    #1 chk("rst_pcready", pc_ready, 1'b1);

    // Three fetches, memory latency 1, decode always ready
    cyc(); pc_valid = 1'b1; pc_in = 16'h0000; instr_ready = 1'b1;
    #1 chk("t1_req0", mem_req, 1'b1); chk("t1_addr0", mem_addr, 16'h0000);
    cyc(); pc_valid = 1'b1; pc_in = 16'h0004; mem_rvalid = 1'b1; mem_rdata = 32'hA0; instr_ready = 1'b1;
    #1 chk("t1_busy_rdy", pc_ready, 1'b0); chk("t1_busy_req", mem_req, 1'b0);
    cyc(); pc_valid = 1'b1; pc_in = 16'h0004; instr_ready = 1'b1;
    #1 chk("t1_req1", mem_req, 1'b1); chk("t1_addr1", mem_addr, 16'h0004);
    chk_head("t1_h0", 16'h0000, 32'hA0);
    cyc(); pc_valid = 1'b1; pc_in = 16'h0008; mem_rvalid = 1'b1; mem_rdata = 32'hA1; instr_ready = 1'b1;
    #1 chk("t1_empty1", instr_valid, 1'b0);
    cyc(); pc_valid = 1'b1; pc_in = 16'h0008; instr_ready = 1'b1;
    #1 chk("t1_req2", mem_req, 1'b1);
    chk_head("t1_h1", 16'h0004, 32'hA1);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hA2; instr_ready = 1'b1;
    cyc(); instr_ready = 1'b1;
    #1 chk_head("t1_h2", 16'h0008, 32'hA2);
    cyc();
    #1 chk("t1_drained", instr_valid, 1'b0); chk("t1_count", dut.count_q, 0);

    // Fill the queue with decode stalled
    for (int i = 0; i < 4; i++) begin
      cyc(); pc_valid = 1'b1; pc_in = 16'h0010 + 16'(4 * i);
      #1 chk("t2_fill_req", mem_req, 1'b1);
      cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hB0 + 32'(i);
    end
    cyc(); pc_valid = 1'b1; pc_in = 16'h0020;
    #1 chk("t2_full_cnt", dut.count_q, 4); chk("t2_full_rdy", pc_ready, 1'b0);
    chk("t2_full_req", mem_req, 1'b0);
    cyc(); pc_valid = 1'b1; pc_in = 16'h0020; instr_ready = 1'b1;
    #1 chk("t2_pop_rdy", pc_ready, 1'b0); chk_head("t2_h0", 16'h0010, 32'hB0);
    cyc(); pc_valid = 1'b1; pc_in = 16'h0020;
    #1 chk("t2_after_pop_rdy", pc_ready, 1'b1); chk("t2_5th_req", mem_req, 1'b1);
    chk("t2_5th_addr", mem_addr, 16'h0020);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hB4;
    cyc(); instr_ready = 1'b1;
    #1 chk("t2_wrap_wp", dut.wr_ptr_q, 0); chk("t2_cnt4", dut.count_q, 4);
    chk_head("t2_h1", 16'h0014, 32'hB1);
    cyc(); instr_ready = 1'b1; #1 chk_head("t2_h2", 16'h0018, 32'hB2);
    cyc(); instr_ready = 1'b1; #1 chk_head("t2_h3", 16'h001C, 32'hB3);
    cyc(); instr_ready = 1'b1; #1 chk_head("t2_h4", 16'h0020, 32'hB4);
    cyc();
    #1 chk("t2_drained", instr_valid, 1'b0);

    // Flush while waiting; late response dropped
    cyc(); pc_valid = 1'b1; pc_in = 16'h0030;
    #1 chk("t3_req", mem_req, 1'b1);
    cyc(); flush = 1'b1;
    #1 chk("t3_flush_rdy", pc_ready, 1'b0);
    cyc();
    #1 chk("t3_drop", dut.state_q, 2'd2); chk("t3_drop_rdy", pc_ready, 1'b0);
    cyc();
    cyc(); pc_valid = 1'b1; pc_in = 16'h0034; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    #1 chk("t3_rv_rdy", pc_ready, 1'b0); chk("t3_rv_ivalid", instr_valid, 1'b0);
    cyc(); pc_valid = 1'b1; pc_in = 16'h0034;
    #1 chk("t3_back_rdy", pc_ready, 1'b1); chk("t3_no_enq", instr_valid, 1'b0);
    chk("t3_cnt", dut.count_q, 0);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hC4;
    cyc(); pc_valid = 1'b1; pc_in = 16'h0038;
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hC8;
    cyc(); pc_valid = 1'b1; pc_in = 16'h003C;
    #1 chk("t4_cnt2", dut.count_q, 2);

    // Flush coinciding with response and pop
    cyc(); flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hEE; instr_ready = 1'b1;
    #1 chk("t4_flush_iv", instr_valid, 1'b0); chk("t4_flush_rdy", pc_ready, 1'b0);
    cyc(); pc_valid = 1'b1; pc_in = 16'h0040;
    #1 chk("t4_state", dut.state_q, 2'd0); chk("t4_cnt", dut.count_q, 0);
    chk("t4_req", mem_req, 1'b1); chk("t4_addr", mem_addr, 16'h0040);
    chk("t4_iv", instr_valid, 1'b0);

    // Push and pop together at count 2
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hD0;
    cyc(); pc_valid = 1'b1; pc_in = 16'h0044;
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hD1;
    cyc(); pc_valid = 1'b1; pc_in = 16'h0048;
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hD2; instr_ready = 1'b1;
    #1 chk("t5_cnt_before", dut.count_q, 2); chk_head("t5_h0", 16'h0040, 32'hD0);
    cyc(); pc_valid = 1'b1; pc_in = 16'h004C; instr_ready = 1'b1;
    #1 chk("t5_cnt_after", dut.count_q, 2); chk_head("t5_h1", 16'h0044, 32'hD1);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hD3;
    #1 chk_head("t5_h2", 16'h0048, 32'hD2);
    cyc(); pc_valid = 1'b1; pc_in = 16'h0050;
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hD4;
    cyc(); pc_valid = 1'b1; pc_in = 16'h0054;
    #1 chk("t6_cnt3", dut.count_q, 3); chk("t6_req", mem_req, 1'b1);

    // Reset mid-WAIT with three entries queued
    cyc(); rst = 1'b0;
    #1 chk("t6_iv", instr_valid, 1'b0); chk("t6_iout", instr_out, 32'h0);
    chk("t6_ipc", instr_pc, 16'h0); chk("t6_mreq", mem_req, 1'b0);
    chk("t6_cnt", dut.count_q, 0); chk("t6_state", dut.state_q, 2'd0);
    cyc(); rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFF;
    cyc();
    #1 chk("t6_late_iv", instr_valid, 1'b0); chk("t6_late_cnt", dut.count_q, 0);
    chk("t6_late_rdy", pc_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
